// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N byte-stream requesters,
// with packet locking, a burst limit and a start-acknowledge timeout.
module uart_tx_arbiter #(
    parameter int N         = 4,
    parameter int BUSY_WAIT = 15,
    parameter int MAX_BURST = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    output logic [N-1:0]   grant,
    output logic           tx_start,
    output logic [7:0]     tx_data,
    input  logic           tx_busy,
    output logic           active,
    output logic           timeout_err
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] owner;
    logic          locked;
    logic          last_q;
    logic [7:0]    wait_cnt;
    logic [7:0]    burst_cnt;

    logic [7:0]    req_bytes [N];
    logic          sel_found;
    logic [PW-1:0] sel_idx;
    logic [PW-1:0] cand;
    logic [N-1:0]  sel_onehot;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
        int unsigned s;
        s = (32'(base) + off) % N;
        return s[PW-1:0];
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_bytes
        assign req_bytes[g] = req_data[8*g +: 8];
    end

    // A locked owner is the only candidate; otherwise the scan runs backwards so the
    // requester closest to rr_ptr is the last one written and therefore wins.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        sel_found  = 1'b0;
        sel_idx    = '0;
        cand       = '0;
        sel_onehot = '0;
        if (!tx_busy) begin
            if (locked) begin
                sel_found = req_valid[owner];
                sel_idx   = owner;
            end else begin
                for (int k = N - 1; k >= 0; k--) begin
                    cand = wrap_add(rr_ptr, k);
                    if (req_valid[cand]) begin
                        sel_found = 1'b1;
                        sel_idx   = cand;
                    end
                end
            end
        end
        if (sel_found) sel_onehot[sel_idx] = 1'b1;
    end

    // NOTE: state and registered outputs use non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            locked      <= 1'b0;
            last_q      <= 1'b0;
            wait_cnt    <= '0;
            burst_cnt   <= '0;
            req_ready   <= '0;
            grant       <= '0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            active      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            req_ready   <= '0;
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            active      <= (state != IDLE);
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        req_ready <= sel_onehot;
                        grant     <= sel_onehot;
                        tx_data   <= req_bytes[sel_idx];
                        owner     <= sel_idx;
                        last_q    <= req_last[sel_idx];
                        locked    <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    tx_start <= 1'b1;
                    wait_cnt <= '0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (wait_cnt == 8'(BUSY_WAIT)) begin
                        // Transmitter never acknowledged: drop the byte and move on.
                        timeout_err <= 1'b1;
                        locked      <= 1'b0;
                        burst_cnt   <= '0;
                        grant       <= '0;
                        rr_ptr      <= wrap_add(owner, 1);
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                        if (last_q || (burst_cnt + 8'd1 == 8'(MAX_BURST))) begin
                            locked    <= 1'b0;
                            burst_cnt <= '0;
                            grant     <= '0;
                            rr_ptr    <= wrap_add(owner, 1);
                        end else begin
                            burst_cnt <= burst_cnt + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single `uart_tx` transmitter among N byte-stream requesters. Requesters are scheduled round-robin, with optional packet locking: a requester keeps the transmitter until it marks a byte as last, or until a burst limit is reached. The block sequences the transmitter's `tx_start`/`tx_busy` handshake one byte at a time and recovers if the transmitter never acknowledges a start. It sits between the producer logic and the `tx_start`/`tx_data`/`tx_busy` ports of `uart_top`.

## Interface
- `N`, 4: number of requesters (2..8).
- `BUSY_WAIT`, 15: cycles allowed after `tx_start` for `tx_busy` to rise (1..255).
- `MAX_BURST`, 16: maximum bytes per grant while locked (1..255).

- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in N: requester i has a byte available.
- `req_data` in 8*N: requester i byte at bits [8i+7:8i].
- `req_last` in N: the byte from requester i ends its packet. Sampled with the data.
- `req_ready` out N: one-hot, one-cycle accept strobe. The byte is consumed when `req_valid[i]` and `req_ready[i]` are both high.
- `grant` out N: one-hot current owner; 0 when no owner.
- `tx_start` out 1: one-cycle start pulse to the transmitter.
- `tx_data` out 8: registered byte, held stable from accept until the return to IDLE.
- `tx_busy` in 1: transmitter busy.
- `active` out 1: high in every state except IDLE.
- `timeout_err` out 1: one-cycle pulse when `tx_busy` fails to rise.

## Operation
- States: IDLE, START, WAIT_BUSY, WAIT_DONE.
- **IDLE, selection:**
  - No selection is made while `tx_busy`=1.
  - If locked, only the owner is eligible. Other requesters wait even if the owner's `req_valid` is low.
  - If unlocked, the first valid requester scanning from `rr_ptr` upward (mod N) is chosen.
- **IDLE, accept:** `req_ready[i]`=1 and `grant`=one-hot(i). `tx_data` <= byte i. The last flag is latched, the lock is set, and the state moves to START.
- **START:** `tx_start`=1 for exactly one cycle. The wait counter clears; the state moves to WAIT_BUSY.
- **WAIT_BUSY:**
  - `tx_busy`=1 moves to WAIT_DONE.
  - Otherwise the counter increments. When it reaches BUSY_WAIT, `timeout_err` pulses, the lock is released, `rr_ptr` <= i+1 mod N, and the state returns to IDLE. The byte is dropped, not retried.
- **WAIT_DONE:** `tx_busy`=0 returns the state to IDLE. The burst count (8-bit) increments.
- **End of packet:** when the latched last flag is set or the burst count reaches MAX_BURST:
  - The lock is released, the burst count clears, `rr_ptr` <= i+1 mod N, and `grant` clears in IDLE.
  - Otherwise the lock and `grant` persist.
- **Simultaneous valid requesters:** the pointer order alone decides; there is no fixed priority.
- **Changes after accept:** `req_valid` dropping or `req_data` changing has no effect on the in-flight byte.
- **Reset mid-operation:** the FSM aborts to IDLE. Any byte being sent by the transmitter finishes independently; the arbiter accepts nothing until `tx_busy`=0.

## Timing
- **Reset values:** `req_ready`=0, `grant`=0, `tx_start`=0, `tx_data`=8'h00, `active`=0, `timeout_err`=0. Internally: `rr_ptr`=0, unlocked, counters 0.
- **Accept to start:** `req_ready` in cycle T, `tx_start` in T+1, WAIT_BUSY from T+2.
- **Byte turnaround:** the next accept occurs 1 cycle after `tx_busy` is seen low in WAIT_DONE. Minimum overhead is 3 cycles beyond the transmitter busy time.
- **Timeout:** `timeout_err` asserts in cycle T+2+BUSY_WAIT when `tx_busy` stays 0. IDLE follows in the next cycle.
- **Outputs:** all are registered; no combinational path from `req_*` to outputs.
- `req_ready` is never high outside the IDLE->START transition cycle and is at most one-hot.

## Test plan
- **Single byte:** reset; `req_valid[2]`=1, data 8'hA5, `req_last[2]`=1.
  - Expect `req_ready`=4'b0100 for 1 cycle, then `tx_start` with `tx_data`=8'hA5.
  - After the bench busy model (busy 1 cycle after start, 20 cycles long), expect `grant`=0 and `rr_ptr`=3.
- **Round-robin:** all four valid, every `req_last`=1, bytes 8'h10..8'h13.
  - Expect transmit order 10,11,12,13, then 10 again with `rr_ptr` wrap 3->0.
- **Packet lock:** requester 1 sends 3 bytes with last on the third; requester 0 is continuously valid.
  - Expect the requester 1 bytes back-to-back with `grant`=4'b0010 throughout, and requester 0 served only afterward.
- **Burst limit:** MAX_BURST=2; requester 3 streams with `req_last`=0.
  - Expect the lock to release after 2 bytes and requester 0 (valid) to be granted next.
- **Timeout:** the busy model never asserts `tx_busy`.
  - Expect `timeout_err` 17 cycles after accept, `active`=0 the next cycle, and the next requester served.
- **Reset mid-transfer:** assert `rst` during WAIT_DONE.
  - Expect all outputs at reset values the next cycle, and no accept until `tx_busy` drops.
